multiply: RTL and testbench



---
 rtl/multiply.sv | 78 +++++++
 tb/tb_multiply.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiply.sv
// Two-stage pipelined unsigned multiplier with valid/ready on both sides.
// S1 holds the operand pair; S2 holds the product. One result per cycle at full throughput.
module multiply #(
  parameter int ARGW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arg_valid,
  output logic                  arg_ready,
  input  logic [1:0][ARGW-1:0]  arg_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*ARGW-1:0]     res_data
);

  localparam int RESW = 2 * ARGW;

  logic            s1_vld_q, s1_vld_d;
  logic [ARGW-1:0] s1_a_q, s1_a_d;
  logic [ARGW-1:0] s1_b_q, s1_b_d;
  logic            s2_vld_q, s2_vld_d;
  logic [RESW-1:0] s2_res_q, s2_res_d;

  logic s2_free;
  logic arg_fire;
  logic res_fire;
  logic s2_load;

  // S2 can take a new product when empty or when its current one leaves this edge.
  assign s2_free   = !s2_vld_q || res_ready;
  assign arg_ready = !s1_vld_q || s2_free;
  assign arg_fire  = arg_valid && arg_ready;
  assign res_fire  = s2_vld_q && res_ready;
  assign s2_load   = s1_vld_q && s2_free;

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s2_vld_d = s2_vld_q;
    s2_res_d = s2_res_q;

    if (arg_fire) begin
      s1_vld_d = 1'b1;
      s1_a_d   = arg_data[0];
      s1_b_d   = arg_data[1];
    end else if (s2_load) begin
      s1_vld_d = 1'b0;
    end

    if (s2_load) begin
      s2_vld_d = 1'b1;
      s2_res_d = RESW'(s1_a_q) * RESW'(s1_b_q);
    end else if (res_fire) begin
      s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s2_vld_q <= 1'b0;
      s2_res_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s2_vld_q <= s2_vld_d;
      s2_res_q <= s2_res_d;
    end
  end

  assign res_valid = s2_vld_q;
  assign res_data  = s2_res_q;

endmodule

// File: tb/tb_multiply.sv
// Bench for multiply: vector table, random stream against a queue model, backpressure and reset sequences.
module tb_multiply;

  localparam int ARGW = 16;
  localparam int RESW = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 arg_valid;
  logic                 arg_ready;
  logic [1:0][ARGW-1:0] arg_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [RESW-1:0]      res_data;

  always #5 clk = ~clk;

  multiply #(.ARGW(ARGW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arg_valid (arg_valid),
    .arg_ready (arg_ready),
    .arg_data  (arg_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [RESW-1:0] exp_q[$];
  logic            held = 1'b0;
  logic [RESW-1:0] held_dat = '0;

  task automatic check(input string name, input logic [RESW-1:0] act, input logic [RESW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: every accepted pair's product is queued; results must come out in the same order.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", RESW'(res_valid), RESW'(1));
        check("hold_data", res_data, held_dat);
      end
      if (res_valid && res_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got %h, expected no result", res_data);
        end else begin
          check("result_order", res_data, exp_q.pop_front());
        end
        n_out++;
      end
      if (arg_valid && arg_ready)
        exp_q.push_back({16'h0, arg_data[0]} * {16'h0, arg_data[1]});
      held     = res_valid && !res_ready;
      held_dat = res_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [ARGW-1:0] a, input logic [ARGW-1:0] b);
    logic acc;
    acc = 1'b0;
    arg_valid = 1'b1;
    arg_data  = {b, a};
    for (int i = 0; i < 50 && !acc; i++) begin
      #1;
      acc = arg_ready;
      step();
    end
    arg_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no acceptance, expected acceptance within 50 cycles");
    end
  endtask

  task automatic wait_drain();
    int i;
    res_ready = 1'b1;
    for (i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !res_valid) break;
      step();
    end
    n_checks++;
    if (i == 100) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  typedef struct {
    string           name;
    logic [ARGW-1:0] a;
    logic [ARGW-1:0] b;
    logic [RESW-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int accepted;
    int out0;
    logic fire;
    logic [ARGW-1:0] bp_a[3];
    logic [ARGW-1:0] bp_b[3];

    vecs[0] = '{"small",    16'd3,    16'd7,    32'd21};
    vecs[1] = '{"max",      16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{"unsigned", 16'h8000, 16'h0002, 32'h00010000};
    vecs[3] = '{"zero",     16'd0,    16'hABCD, 32'd0};
    vecs[4] = '{"one",      16'd1,    16'h1234, 32'h00001234};
    vecs[5] = '{"mixed",    16'h0100, 16'h0100, 32'h00010000};

    rst_n     = 1'b0;
    arg_valid = 1'b0;
    arg_data  = '0;
    res_ready = 1'b0;
    step();
    step();
    check("rst_res_valid", RESW'(res_valid), RESW'(0));
    check("rst_res_data",  res_data, 32'd0);
    check("rst_arg_ready", RESW'(arg_ready), RESW'(1));
    rst_n = 1'b1;
    step();
    check("post_rst_arg_ready", RESW'(arg_ready), RESW'(1));

    // Single transfers: 2-cycle latency, operands ignored outside the transfer edge.
    for (int i = 0; i < 6; i++) begin
      arg_valid = 1'b1;
      arg_data  = {vecs[i].b, vecs[i].a};
      res_ready = 1'b1;
      #1;
      check({vecs[i].name, "_arg_ready"}, RESW'(arg_ready), RESW'(1));
      step();
      arg_valid = 1'b0;
      arg_data  = {16'h5A5A, 16'hC3C3};
      check({vecs[i].name, "_lat1_valid"}, RESW'(res_valid), RESW'(0));
      step();
      check({vecs[i].name, "_lat2_valid"}, RESW'(res_valid), RESW'(1));
      check({vecs[i].name, "_data"}, res_data, vecs[i].exp);
      step();
      check({vecs[i].name, "_after_valid"}, RESW'(res_valid), RESW'(0));
    end

    // Random back-to-back stream with random downstream stalls.
    accepted = 0;
    arg_valid = 1'b1;
    arg_data  = {16'($urandom), 16'($urandom)};
    for (int c = 0; c < 200 && accepted < 8; c++) begin
      res_ready = 1'($urandom_range(0, 1));
      #1;
      fire = arg_ready;
      step();
      if (fire) begin
        accepted++;
        arg_data = {16'($urandom), 16'($urandom)};
      end
    end
    arg_valid = 1'b0;
    check("rand_accepted", RESW'(accepted), RESW'(8));
    wait_drain();

    // Backpressure: only two pairs fit while res_ready is low.
    bp_a[0] = 16'd11;   bp_b[0] = 16'd13;
    bp_a[1] = 16'h1234; bp_b[1] = 16'h0010;
    bp_a[2] = 16'hFFFF; bp_b[2] = 16'd2;
    out0 = n_out;
    res_ready = 1'b0;
    accepted = 0;
    arg_valid = 1'b1;
    arg_data  = {bp_b[0], bp_a[0]};
    for (int c = 0; c < 6; c++) begin
      #1;
      fire = arg_ready;
      step();
      if (fire) begin
        accepted++;
        if (accepted < 3) arg_data = {bp_b[accepted], bp_a[accepted]};
      end
    end
    check("bp_accepted", RESW'(accepted), RESW'(2));
    check("bp_arg_ready_low", RESW'(arg_ready), RESW'(0));
    check("bp_res_valid", RESW'(res_valid), RESW'(1));
    check("bp_res_data", res_data, 32'd143);
    res_ready = 1'b1;
    #1;
    check("bp_arg_ready_same_cycle", RESW'(arg_ready), RESW'(1));
    step();
    arg_valid = 1'b0;
    wait_drain();
    check("bp_outputs", RESW'(n_out - out0), RESW'(3));

    // Reset with two results in flight.
    res_ready = 1'b0;
    send_one(16'd5, 16'd6);
    send_one(16'd7, 16'd8);
    check("inflight_res_valid", RESW'(res_valid), RESW'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_res_valid", RESW'(res_valid), RESW'(0));
    check("midrst_res_data", res_data, 32'd0);
    check("midrst_arg_ready", RESW'(arg_ready), RESW'(1));
    step();
    step();
    rst_n = 1'b1;
    step();
    check("postrst_res_valid", RESW'(res_valid), RESW'(0));
    out0 = n_out;
    send_one(16'd10, 16'd10);
    step();
    check("postrst_new_valid", RESW'(res_valid), RESW'(1));
    check("postrst_new_data", res_data, 32'd100);
    wait_drain();
    for (int c = 0; c < 5; c++) step();
    check("postrst_outputs", RESW'(n_out - out0), RESW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
